// File: rtl/rs_tx_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs_tx_serializer_pkg                                         |
// | Description : Shared definitions for the RS-232 transmit path: FSM state   |
// |               encodings, parity mode constants, default bit period for a   |
// |               50 MHz clock at 115200 baud, and a parity helper.            |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package rs_tx_serializer_pkg;

    // Transmit FSM state encodings
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    // Parity modes
    localparam int c_parity_none = 0;
    localparam int c_parity_odd  = 1;
    localparam int c_parity_even = 2;

    // 50 MHz / 115200 baud, rounded
    localparam int c_clk_div_default = 434;

    // Parity bit to append to a byte for the given mode. Even parity makes the
    // total count of ones even, so the bit is the plain XOR; odd inverts it.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic w_x;
        w_x = ^data;
        parity_bit = (mode == c_parity_odd) ? ~w_x : w_x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rs_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs_baud_tick                                                 |
// | Description : Bit-period counter. Counts 0..CLK_DIV-1 and flags the last   |
// |               cycle of each period; held at zero while i_clear is high so  |
// |               the first period starts exactly when i_clear drops.          |
// | Ports       : clk      - system clock                                      |
// |               reset_n  - synchronous active-low reset                      |
// |               i_clear  - hold counter at zero                              |
// |               o_tick   - high in the last cycle of each bit period         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rs_baud_tick
    import rs_tx_serializer_pkg::*;
#(
    parameter int CLK_DIV = c_clk_div_default
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [15:0] c_last = 16'(CLK_DIV - 1);

    logic [15:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == c_last) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign o_tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/rs_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rs_tx_serializer                                             |
// | Description : UART transmit serializer. Accepts one byte per start pulse   |
// |               while idle and sends start bit, 8 data bits LSB first,       |
// |               optional parity and 1 or 2 stop bits on txd.                 |
// | Ports       : clk          - system clock                                  |
// |               reset_n      - synchronous active-low reset                  |
// |               rs_tx_start  - byte request, honoured only when idle         |
// |               rs_tx_data   - byte captured on the accepting edge           |
// |               rs_tx_status - busy, high while a frame is in flight         |
// |               txd          - serial line, idles at mark (1)                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rs_tx_serializer
    import rs_tx_serializer_pkg::*;
#(
    parameter int CLK_DIV   = c_clk_div_default,
    parameter int PARITY    = c_parity_none,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rs_tx_start,
    input  logic [7:0] rs_tx_data,
    output logic       rs_tx_status,
    output logic       txd
);

    localparam logic [2:0] c_last_stop = 3'(STOP_BITS - 1);
    localparam logic [2:0] c_last_data = 3'd7;

    logic [2:0] r_state;
    logic [7:0] r_shift;
    logic [7:0] r_par_byte;   // untouched copy of the byte for the parity bit
    logic [2:0] r_bit_cnt;
    logic       r_status;
    logic       r_txd;
    logic       w_tick;
    logic       w_clear;

    // Counter sits at zero throughout IDLE so the start bit gets a full period
    assign w_clear = (r_state == c_st_idle);

    rs_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= c_st_idle;
            r_shift    <= 8'd0;
            r_par_byte <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_status   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_txd    <= 1'b1;
                    r_status <= 1'b0;
                    if (rs_tx_start) begin
                        r_shift    <= rs_tx_data;
                        r_par_byte <= rs_tx_data;
                        r_status   <= 1'b1;
                        r_txd      <= 1'b0;
                        r_state    <= c_st_start;
                    end
                end

                // The shift register is pre-shifted as each bit goes out, so
                // r_shift[0] is always the next data bit to present.
                c_st_start: begin
                    if (w_tick) begin
                        r_txd     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_cnt <= 3'd0;
                        r_state   <= c_st_data;
                    end
                end

                c_st_data: begin
                    if (w_tick) begin
                        if (r_bit_cnt == c_last_data) begin
                            r_bit_cnt <= 3'd0;
                            if (PARITY != c_parity_none) begin
                                r_txd   <= parity_bit(r_par_byte, PARITY);
                                r_state <= c_st_parity;
                            end else begin
                                r_txd   <= 1'b1;
                                r_state <= c_st_stop;
                            end
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end

                c_st_parity: begin
                    if (w_tick) begin
                        r_txd     <= 1'b1;
                        r_bit_cnt <= 3'd0;
                        r_state   <= c_st_stop;
                    end
                end

                // r_bit_cnt counts completed stop bits
                c_st_stop: begin
                    r_txd <= 1'b1;
                    if (w_tick) begin
                        if (r_bit_cnt == c_last_stop) begin
                            r_bit_cnt <= 3'd0;
                            r_status  <= 1'b0;
                            r_state   <= c_st_idle;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end

                default: begin
                    r_txd     <= 1'b1;
                    r_status  <= 1'b0;
                    r_bit_cnt <= 3'd0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    assign rs_tx_status = r_status;
    assign txd          = r_txd;

endmodule
`default_nettype wire

// File: tb/tb_rs_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rs_tx_serializer                                          |
// | Description : Self-checking bench. Four serializers with different parity  |
// |               and stop-bit settings share one input stream; each is        |
// |               compared cycle by cycle against a frame-level model, and a   |
// |               serial decoder recovers the bytes actually sent.             |
// | Ports       : none                                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_rs_tx_serializer;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] data;
    logic [3:0] st;
    logic [3:0] tx;

    always #5 clk = ~clk;

    // Unit configurations: {parity, stop bits}
    function automatic int p_of(input int i);
        case (i)
            1:       p_of = 2;
            2:       p_of = 1;
            default: p_of = 0;
        endcase
    endfunction

    function automatic int s_of(input int i);
        s_of = (i >= 2) ? 2 : 1;
    endfunction

    rs_tx_serializer #(.CLK_DIV(DIV), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .rs_tx_start(start), .rs_tx_data(data),
        .rs_tx_status(st[0]), .txd(tx[0]));
    rs_tx_serializer #(.CLK_DIV(DIV), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .rs_tx_start(start), .rs_tx_data(data),
        .rs_tx_status(st[1]), .txd(tx[1]));
    rs_tx_serializer #(.CLK_DIV(DIV), .PARITY(1), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .rs_tx_start(start), .rs_tx_data(data),
        .rs_tx_status(st[2]), .txd(tx[2]));
    rs_tx_serializer #(.CLK_DIV(DIV), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .rs_tx_start(start), .rs_tx_data(data),
        .rs_tx_status(st[3]), .txd(tx[3]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Serial bits of a frame, index 0 first on the wire; unused tail is mark.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input int p);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        if (p == 1) f[9] = ($countones(d) % 2 == 0);
        if (p == 2) f[9] = ($countones(d) % 2 == 1);
        return f;
    endfunction

    function automatic int frame_len(input int i);
        frame_len = (9 + ((p_of(i) != 0) ? 1 : 0) + s_of(i)) * DIV;
    endfunction

    // Reference model: remaining cycles of the current frame and position in it
    int          m_left [4];
    int          m_pos  [4];
    logic [11:0] m_bits [4];

    // Serial decoder state and received log
    int         dcnt    [4];
    logic [7:0] dsh     [4];
    logic       dpar    [4];
    logic [7:0] rx_buf  [4][16];
    logic       rx_par  [4][16];
    logic       rx_stop [4][16];
    int         rx_n    [4];

    // Busy-length measurement
    int   blen     [4];
    int   last_len [4];
    logic prev_st  [4];

    task automatic tick();
        int   k;
        logic exp_st;
        logic exp_tx;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
                m_left[i] = 0;
            end else if (m_left[i] == 0) begin
                if (start) begin
                    m_bits[i] = frame_bits(data, p_of(i));
                    m_left[i] = frame_len(i);
                    m_pos[i]  = 0;
                end
            end else begin
                m_left[i]--;
                m_pos[i]++;
            end
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_st = (m_left[i] != 0);
            exp_tx = exp_st ? m_bits[i][m_pos[i] / DIV] : 1'b1;
            chk($sformatf("cycle_u%0d_status_txd", i), {30'd0, st[i], tx[i]}, {30'd0, exp_st, exp_tx});

            // decoder: sample each bit at its midpoint
            if (!reset_n) begin
                dcnt[i] = -1;
            end else if (dcnt[i] < 0) begin
                if (tx[i] == 1'b0) dcnt[i] = 0;
            end else begin
                dcnt[i]++;
            end
            if (dcnt[i] >= 0 && (dcnt[i] % DIV) == DIV / 2) begin
                k = dcnt[i] / DIV;
                if (k >= 1 && k <= 8) dsh[i][k - 1] = tx[i];
                if (p_of(i) != 0 && k == 9) dpar[i] = tx[i];
                if (k == 9 + ((p_of(i) != 0) ? 1 : 0)) begin
                    if (rx_n[i] < 16) begin
                        rx_buf[i][rx_n[i]]  = dsh[i];
                        rx_par[i][rx_n[i]]  = dpar[i];
                        rx_stop[i][rx_n[i]] = tx[i];
                    end
                    rx_n[i]++;
                    dcnt[i] = -1;
                end
            end

            // busy length
            if (st[i]) blen[i] = prev_st[i] ? blen[i] + 1 : 1;
            else if (prev_st[i] && reset_n) last_len[i] = blen[i];
            prev_st[i] = st[i];
        end
    endtask

    task automatic clear_rx();
        for (int i = 0; i < 4; i++) rx_n[i] = 0;
    endtask

    task automatic send(input logic [7:0] b);
        start = 1'b1;
        data  = b;
        tick();
        start = 1'b0;
        data  = $urandom;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic wait_idle(input string name);
        int c;
        c = 0;
        while (st != 4'd0 && c < 200) begin
            tick();
            c++;
        end
        if (c >= 200) chk({name, "_idle_timeout"}, 1, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
    } vec_t;

    vec_t vecs [8];
    logic [7:0] msg [12];

    initial begin
        vecs[0] = '{8'h41, 1'b0, 1'b1};
        vecs[1] = '{8'h00, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h7F, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b1};
        vecs[7] = '{8'h80, 1'b1, 1'b0};
        msg = '{8'h30, 8'h31, 8'h20, 8'h32, 8'h33, 8'h20,
                8'h34, 8'h35, 8'h20, 8'h36, 8'h37, 8'h0A};

        for (int i = 0; i < 4; i++) begin
            m_left[i] = 0; m_pos[i] = 0; m_bits[i] = '1;
            dcnt[i] = -1; dsh[i] = 8'd0; dpar[i] = 1'b0;
            rx_n[i] = 0; blen[i] = 0; last_len[i] = 0; prev_st[i] = 1'b0;
        end

        reset_n = 1'b0;
        start   = 1'b0;
        data    = 8'h00;
        run(4);
        chk("reset_txd", {28'd0, tx}, 32'hF);
        chk("reset_status", {28'd0, st}, 32'h0);
        reset_n = 1'b1;
        run(3);

        // Table: single frames, decoded byte, parity bit and busy length
        for (int v = 0; v < 8; v++) begin
            clear_rx();
            send(vecs[v].data);
            chk($sformatf("v%0d_status_after_start", v), {28'd0, st}, 32'hF);
            run(60);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("v%0d_u%0d_count", v, i), rx_n[i], 1);
                chk($sformatf("v%0d_u%0d_byte", v, i), int'(rx_buf[i][0]), int'(vecs[v].data));
                chk($sformatf("v%0d_u%0d_stop", v, i), int'(rx_stop[i][0]), 1);
                chk($sformatf("v%0d_u%0d_len", v, i), last_len[i], (i == 1 || i == 3) ? 44 : (i == 2 ? 48 : 40));
                if (i == 1) chk($sformatf("v%0d_even_par", v), int'(rx_par[1][0]), int'(vecs[v].par_even));
                if (i == 2) chk($sformatf("v%0d_odd_par", v), int'(rx_par[2][0]), int'(vecs[v].par_odd));
            end
        end

        // Start while busy is ignored
        clear_rx();
        send(8'hA5);
        run(9);
        send(8'h55);
        run(70);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("busy_u%0d_count", i), rx_n[i], 1);
            chk($sformatf("busy_u%0d_byte", i), int'(rx_buf[i][0]), 32'hA5);
        end

        // Reset in the middle of a frame, then a clean frame
        clear_rx();
        send(8'hFF);
        run(12);
        reset_n = 1'b0;
        tick();
        chk("midreset_txd", {28'd0, tx}, 32'hF);
        chk("midreset_status", {28'd0, st}, 32'h0);
        reset_n = 1'b1;
        run(3);
        clear_rx();
        send(8'h3C);
        run(60);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("postreset_u%0d_count", i), rx_n[i], 1);
            chk($sformatf("postreset_u%0d_byte", i), int'(rx_buf[i][0]), 32'h3C);
        end

        // Upstream-style handshake: issue only when every unit is idle
        clear_rx();
        for (int b = 0; b < 12; b++) begin
            wait_idle("handshake");
            send(msg[b]);
            tick();
        end
        wait_idle("handshake_end");
        run(4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("msg_u%0d_count", i), rx_n[i], 12);
            for (int b = 0; b < 12; b++)
                chk($sformatf("msg_u%0d_b%0d", i, b), int'(rx_buf[i][b]), int'(msg[b]));
        end

        // Start held high: back-to-back frames, one mark cycle apart
        start = 1'b1;
        data  = 8'h5A;
        run(150);
        start = 1'b0;
        run(60);

        // Random traffic with occasional resets; the model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom_range(0, 5) == 0);
            data    = $urandom;
            reset_n = ($urandom_range(0, 399) != 0);
            tick();
        end
        reset_n = 1'b1;
        start   = 1'b0;
        run(60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
